alu_op_sequencer: RTL and testbench

//  Upstream front-end of the multi-cycle 8-bit ALU. Accepts one operation request
//  (opcode + up to three 8-bit operand words) over a valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_watchdog.sv | 27 ++
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// the latched request record and per-opcode word-count helpers.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } req_t;

    // Operand words sent to the ALU: the divider needs a 16-bit dividend plus divisor.
    function automatic logic [1:0] n_in(input logic [1:0] op);
        return (op == OP_DIV) ? 2'd3 : 2'd2;
    endfunction

    // Result words returned by the ALU: mul and div produce a two-byte result.
    function automatic logic [1:0] n_res(input logic [1:0] op);
        return (op == OP_MUL || op == OP_DIV) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// WAIT-state cycle counter with expiry flag; instantiated by alu_op_sequencer
// only when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Held at zero outside WAIT, so it is already clear on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset || !in_wait) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = in_wait && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end for the multi-cycle 8-bit ALU: accepts a request, pulses the ALU,
// serialises operands, gathers the result and returns it as a 16-bit response.
// Optional WAIT timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    state_t     state;
    req_t       req_q;
    logic [1:0] word_cnt;
    logic [7:0] prev;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic wd_expired;

    alu_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .in_wait (state == ST_WAIT),
        .expired (wd_expired)
    );
`else
    assign rsp_err = 1'b0;
`endif

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every branch reads the values from before this edge, never a half-updated mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            word_cnt    <= 2'd0;
            prev        <= 8'h00;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'h0000;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
`ifdef ALU_SEQ_TIMEOUT_EN
            rsp_err     <= 1'b0;
`endif
        end else begin
            // Last-sampled result byte; forms the hi half of two-word results.
            prev      <= alu_outbus;
            alu_begin <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q       <= '{op: req_op, a: req_a, b: req_b, c: req_c};
                        req_ready   <= 1'b0;
                        alu_begin   <= 1'b1;
                        alu_op_code <= req_op;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    alu_inbus <= req_q.a;
                    word_cnt  <= 2'd0;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (word_cnt == n_in(req_q.op) - 2'd1) begin
                        alu_inbus <= 8'h00;
                        state     <= ST_WAIT;
                    end else begin
                        word_cnt  <= word_cnt + 2'd1;
                        alu_inbus <= (word_cnt == 2'd0) ? req_q.b : req_q.c;
                    end
                end

                ST_WAIT: begin
                    // A real completion takes priority over a timeout expiring this cycle.
                    if (alu_end) begin
                        rsp_data    <= (n_res(req_q.op) == 2'd2) ? {prev, alu_outbus}
                                                                 : {8'h00, alu_outbus};
                        rsp_valid   <= 1'b1;
                        alu_op_code <= 2'b00;
                        state       <= ST_RESP;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (wd_expired) begin
                        rsp_data    <= 16'h0000;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        alu_op_code <= 2'b00;
                        state       <= ST_RESP;
                    end
`endif
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table-driven operations against a
// scripted ALU model plus hand-written backpressure, reset and timeout sequences.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [7:0]  req_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_end;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end)
    );

    always #5 clk = ~clk;

    // d = WAIT cycle in which the ALU raises END (0 = never); hi/lo = scripted outbus words.
    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        int          d;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one request and plays the ALU; returns with the DUT in RESP.
    task automatic do_op(input vec_t v, input string tag);
        int nin;
        int nwait;
        logic [7:0] words [3];
        nin      = (v.op == 2'b11) ? 3 : 2;
        nwait    = (v.d == 0) ? 8 : v.d;
        words[0] = v.a;
        words[1] = v.b;
        words[2] = v.c;

        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_c     = v.c;
        check({tag, " req_ready idle"}, 16'(req_ready), 16'h1);
        tick();
        req_valid = 1'b0;
        check({tag, " alu_begin start"}, 16'(alu_begin), 16'h1);
        check({tag, " op_code start"}, 16'(alu_op_code), 16'(v.op));
        check({tag, " req_ready busy"}, 16'(req_ready), 16'h0);
        tick();
        for (int k = 0; k < nin; k++) begin
            check($sformatf("%s inbus word%0d", tag, k), 16'(alu_inbus), 16'(words[k]));
            check($sformatf("%s begin low send%0d", tag, k), 16'(alu_begin), 16'h0);
            check($sformatf("%s op_code send%0d", tag, k), 16'(alu_op_code), 16'(v.op));
            if (k == nin - 1) alu_outbus = v.hi;
            tick();
        end
        for (int i = 1; i <= nwait; i++) begin
            check($sformatf("%s inbus idle wait%0d", tag, i), 16'(alu_inbus), 16'h0);
            check($sformatf("%s no rsp wait%0d", tag, i), 16'(rsp_valid), 16'h0);
            if (v.d != 0 && i == v.d) begin
                alu_outbus = v.lo;
                alu_end    = 1'b1;
            end
            tick();
        end
        alu_end    = 1'b0;
        alu_outbus = 8'h5A;
    endtask

    task automatic check_resp(input vec_t v, input logic err, input string tag);
        check({tag, " rsp_valid"}, 16'(rsp_valid), 16'h1);
        check({tag, " rsp_data"}, rsp_data, err ? 16'h0000 : v.exp);
        check({tag, " rsp_err"}, 16'(rsp_err), 16'(err));
        check({tag, " op_code resp"}, 16'(alu_op_code), 16'h0);
        check({tag, " req_ready resp"}, 16'(req_ready), 16'h0);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_valid cleared"}, 16'(rsp_valid), 16'h0);
        check({tag, " req_ready back"}, 16'(req_ready), 16'h1);
        check({tag, " rsp_err cleared"}, 16'(rsp_err), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;

        vecs[0] = '{op: 2'b00, a: 8'h05, b: 8'h03, c: 8'h00, d: 2, hi: 8'hAA, lo: 8'h08, exp: 16'h0008};
        vecs[1] = '{op: 2'b10, a: 8'h10, b: 8'h10, c: 8'h00, d: 3, hi: 8'h01, lo: 8'h00, exp: 16'h0100};
        vecs[2] = '{op: 2'b11, a: 8'h00, b: 8'h64, c: 8'h07, d: 4, hi: 8'h02, lo: 8'h0E, exp: 16'h020E};
        vecs[3] = '{op: 2'b01, a: 8'h09, b: 8'h04, c: 8'h00, d: 1, hi: 8'hAA, lo: 8'h05, exp: 16'h0005};
        vecs[4] = '{op: 2'b10, a: 8'h7F, b: 8'h79, c: 8'h00, d: 1, hi: 8'h3C, lo: 8'h07, exp: 16'h3C07};
        vecs[5] = '{op: 2'b10, a: 8'hFF, b: 8'hFF, c: 8'h00, d: 8, hi: 8'hFE, lo: 8'h01, exp: 16'hFE01};
        vecs[6] = '{op: 2'b11, a: 8'h01, b: 8'h00, c: 8'h10, d: 5, hi: 8'h00, lo: 8'h10, exp: 16'h0010};
        vecs[7] = '{op: 2'b00, a: 8'hFF, b: 8'h01, c: 8'h00, d: 3, hi: 8'hAA, lo: 8'h00, exp: 16'h0000};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 8'h00;
        req_b      = 8'h00;
        req_c      = 8'h00;
        rsp_ready  = 1'b0;
        alu_outbus = 8'h00;
        alu_end    = 1'b0;
        repeat (3) tick();

        check("reset req_ready", 16'(req_ready), 16'h1);
        check("reset rsp_valid", 16'(rsp_valid), 16'h0);
        check("reset rsp_data", rsp_data, 16'h0000);
        check("reset rsp_err", 16'(rsp_err), 16'h0);
        check("reset alu_begin", 16'(alu_begin), 16'h0);
        check("reset alu_op_code", 16'(alu_op_code), 16'h0);
        check("reset alu_inbus", 16'(alu_inbus), 16'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
            check_resp(vecs[i], 1'b0, $sformatf("vec%0d", i));
            finish_rsp($sformatf("vec%0d", i));
        end

        // Backpressure: response held while a new request waits, then accepted.
        do_op(vecs[1], "bp");
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = vecs[0].op;
            req_a     = vecs[0].a;
            req_b     = vecs[0].b;
            req_c     = 8'h00;
            check($sformatf("bp rsp_valid hold%0d", i), 16'(rsp_valid), 16'h1);
            check($sformatf("bp rsp_data hold%0d", i), rsp_data, 16'h0100);
            check($sformatf("bp req_ready hold%0d", i), 16'(req_ready), 16'h0);
            check($sformatf("bp no begin hold%0d", i), 16'(alu_begin), 16'h0);
            tick();
        end
        finish_rsp("bp");
        do_op(vecs[0], "bp_next");
        check_resp(vecs[0], 1'b0, "bp_next");
        finish_rsp("bp_next");

        // Reset in the middle of a divide's operand transfer.
        v = '{op: 2'b11, a: 8'h12, b: 8'h64, c: 8'h07, d: 2, hi: 8'h00, lo: 8'h00, exp: 16'h0000};
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_c     = v.c;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_mid inbus word0", 16'(alu_inbus), 16'h0012);
        tick();
        check("rst_mid inbus word1", 16'(alu_inbus), 16'h0064);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid req_ready", 16'(req_ready), 16'h1);
        check("rst_mid inbus", 16'(alu_inbus), 16'h0);
        check("rst_mid rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_mid op_code", 16'(alu_op_code), 16'h0);
        alu_end    = 1'b1;
        alu_outbus = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stray end rsp_valid%0d", i), 16'(rsp_valid), 16'h0);
            check($sformatf("stray end req_ready%0d", i), 16'(req_ready), 16'h1);
        end
        alu_end = 1'b0;
        do_op(vecs[0], "post_rst");
        check_resp(vecs[0], 1'b0, "post_rst");
        finish_rsp("post_rst");

`ifdef ALU_SEQ_TIMEOUT_EN
        // ALU never completes: abort after eight WAIT cycles.
        v = '{op: 2'b10, a: 8'h03, b: 8'h04, c: 8'h00, d: 0, hi: 8'h11, lo: 8'h22, exp: 16'h0000};
        do_op(v, "timeout");
        check_resp(v, 1'b1, "timeout");
        finish_rsp("timeout");
        do_op(vecs[3], "after_to");
        check_resp(vecs[3], 1'b0, "after_to");
        finish_rsp("after_to");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
